// File: rtl/time_counter.sv
// time_counter: 1 Hz prescaler and 24-hour BCD time of day with set-mode buttons.
// Defining TIME_ALARM_EN adds the ahour/amin ports and the registered alarm comparator.
module time_counter #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_mode,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       clr_sec,
`ifdef TIME_ALARM_EN
  input  logic [7:0] ahour,
  input  logic [7:0] amin,
`endif
  output logic [7:0] hour1,
  output logic [7:0] min1,
  output logic [7:0] sec1,
  output logic       tick_1hz,
  output logic       alarm
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre, pre_d;
  logic [7:0]    hour_d, min_d, sec_d;
  logic          inc_hour_q, inc_min_q, clr_sec_q;
  logic          s, hour_rise, min_rise, clr_rise;

  // BCD +1 with wrap at top; the wrap compare is on the whole byte.
  function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      return 8'h00;
    else if (v[3:0] == 4'h9)
      return {v[7:4] + 4'h1, 4'h0};
    else
      return {v[7:4], v[3:0] + 4'h1};
  endfunction

  assign s         = (pre == PRE_MAX) && !set_mode;
  assign hour_rise = inc_hour && !inc_hour_q;
  assign min_rise  = inc_min && !inc_min_q;
  assign clr_rise  = clr_sec && !clr_sec_q;

  always_comb begin
    pre_d = pre + 1'b1;
    if (clr_rise || s || set_mode)
      pre_d = '0;
  end

  // Run-mode carries and set-mode buttons are mutually exclusive via s.
  always_comb begin
    sec_d  = sec1;
    min_d  = min1;
    hour_d = hour1;
    if (clr_rise) begin
      sec_d = 8'h00;
    end else if (s) begin
      sec_d = inc_bcd(sec1, 8'h59);
      if (sec1 == 8'h59) begin
        min_d = inc_bcd(min1, 8'h59);
        if (min1 == 8'h59)
          hour_d = inc_bcd(hour1, 8'h23);
      end
    end
    if (set_mode) begin
      if (min_rise)
        min_d = inc_bcd(min1, 8'h59);
      if (hour_rise)
        hour_d = inc_bcd(hour1, 8'h23);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre        <= '0;
      sec1       <= 8'h00;
      min1       <= 8'h00;
      hour1      <= 8'h00;
      tick_1hz   <= 1'b0;
      inc_hour_q <= 1'b0;
      inc_min_q  <= 1'b0;
      clr_sec_q  <= 1'b0;
    end else begin
      pre        <= pre_d;
      sec1       <= sec_d;
      min1       <= min_d;
      hour1      <= hour_d;
      tick_1hz   <= s;
      inc_hour_q <= inc_hour;
      inc_min_q  <= inc_min;
      clr_sec_q  <= clr_sec;
    end
  end

`ifdef TIME_ALARM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      alarm <= 1'b0;
    else
      alarm <= (hour1 == ahour) && (min1 == amin) && !set_mode;
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with TICK_DIV = 4; alarm steps build only with TIME_ALARM_EN.
module tb_time_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_mode = 1'b0;
  logic       inc_hour = 1'b0;
  logic       inc_min = 1'b0;
  logic       clr_sec = 1'b0;
`ifdef TIME_ALARM_EN
  logic [7:0] ahour = 8'h07;
  logic [7:0] amin = 8'h30;
`endif
  logic [7:0] hour1, min1, sec1;
  logic       tick_1hz, alarm;
  int         passed = 0;
  int         total = 0;
  int         ticks;

  time_counter #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .set_mode (set_mode),
    .inc_hour (inc_hour),
    .inc_min  (inc_min),
    .clr_sec  (clr_sec),
`ifdef TIME_ALARM_EN
    .ahour    (ahour),
    .amin     (amin),
`endif
    .hour1    (hour1),
    .min1     (min1),
    .sec1     (sec1),
    .tick_1hz (tick_1hz),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_hour(input int n);
    repeat (n) begin
      inc_hour = 1'b1; cyc(1);
      inc_hour = 1'b0; cyc(1);
    end
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin
      inc_min = 1'b1; cyc(1);
      inc_min = 1'b0; cyc(1);
    end
  endtask

  task automatic pulse_clr();
    clr_sec = 1'b1; cyc(1);
    clr_sec = 1'b0; cyc(1);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    // reset state
    cyc(2);
    chk("rst_hour", hour1, 8'h00);
    chk("rst_min", min1, 8'h00);
    chk("rst_sec", sec1, 8'h00);
    chk("rst_tick", {7'd0, tick_1hz}, 8'h00);
    chk("rst_alarm", {7'd0, alarm}, 8'h00);

    // reset reasserted mid-count acts asynchronously
    rst = 1'b0; cyc(2);
    #2 rst = 1'b1;
    #1 chk("async_rst_sec", sec1, 8'h00);
    chk("async_rst_tick", {7'd0, tick_1hz}, 8'h00);
    @(negedge clk); rst = 1'b0;

    // first advance on the 4th edge, tick for one cycle
    cyc(3);
    chk("first_sec_pre", sec1, 8'h00);
    chk("first_tick_pre", {7'd0, tick_1hz}, 8'h00);
    cyc(1);
    chk("first_sec", sec1, 8'h01);
    chk("first_tick", {7'd0, tick_1hz}, 8'h01);
    cyc(1);
    chk("first_tick_end", {7'd0, tick_1hz}, 8'h00);
    chk("first_sec_hold", sec1, 8'h01);

    // set 23:59 in set mode, seconds frozen, then clear seconds
    set_mode = 1'b1;
    pulse_hour(23);
    pulse_min(59);
    chk("set_hour23", hour1, 8'h23);
    chk("set_min59", min1, 8'h59);
    chk("set_sec_frozen", sec1, 8'h01);
    pulse_clr();
    chk("set_clr_sec", sec1, 8'h00);
    set_mode = 1'b0;
    cyc(4 * 58);
    chk("run_to_58", sec1, 8'h58);
    chk("run_to_58_min", min1, 8'h59);

    // full rollover 23:59:59 -> 00:00:00
    ticks = 0;
    repeat (4) begin cyc(1); ticks += int'(tick_1hz); end
    chk("roll_sec59", sec1, 8'h59);
    chk("roll_hour23", hour1, 8'h23);
    repeat (4) begin cyc(1); ticks += int'(tick_1hz); end
    chk("roll_hour", hour1, 8'h00);
    chk("roll_min", min1, 8'h00);
    chk("roll_sec", sec1, 8'h00);
    chk("roll_ticks", 8'(ticks), 8'd2);

    // set mode: held inc_min counts once, wraps without hour carry
    set_mode = 1'b1;
    pulse_min(59);
    chk("setm_min59", min1, 8'h59);
    inc_min = 1'b1; cyc(1);
    chk("hold_min_wrap", min1, 8'h00);
    cyc(9);
    chk("hold_min_once", min1, 8'h00);
    chk("hold_hour_same", hour1, 8'h00);
    inc_min = 1'b0; cyc(1);
    pulse_hour(23);
    chk("seth_23", hour1, 8'h23);
    pulse_hour(1);
    chk("seth_wrap", hour1, 8'h00);
    chk("setm_sec_frozen", sec1, 8'h00);
    inc_hour = 1'b1; inc_min = 1'b1; cyc(1);
    chk("both_hour", hour1, 8'h01);
    chk("both_min", min1, 8'h01);
    inc_hour = 1'b0; inc_min = 1'b0; cyc(1);

    // run mode discards inc buttons; clr_sec restarts the second
    set_mode = 1'b0;
    pulse_hour(1);
    pulse_min(1);
    cyc(144);
    chk("disc_hour", hour1, 8'h01);
    chk("disc_min", min1, 8'h01);
    chk("disc_sec37", sec1, 8'h37);
    cyc(2);
    clr_sec = 1'b1; cyc(1);
    chk("clr_run_sec", sec1, 8'h00);
    clr_sec = 1'b0; cyc(3);
    chk("clr_pre_hold", sec1, 8'h00);
    cyc(1);
    chk("clr_next_adv", sec1, 8'h01);
`ifndef TIME_ALARM_EN
    chk("alarm_tied0", {7'd0, alarm}, 8'h00);
`endif

    // clr_sec coincident with the strobe at :59 wins, no minute carry
    set_mode = 1'b1;
    pulse_min(9);
    pulse_clr();
    chk("sim_setup_min", min1, 8'h10);
    chk("sim_setup_sec", sec1, 8'h00);
    set_mode = 1'b0;
    cyc(236);
    chk("sim_sec59", sec1, 8'h59);
    cyc(3);
    clr_sec = 1'b1; cyc(1);
    chk("sim_sec", sec1, 8'h00);
    chk("sim_min", min1, 8'h10);
    clr_sec = 1'b0; cyc(1);

`ifdef TIME_ALARM_EN
    // alarm at 07:30, one cycle lag, drops at 07:31 and on set mode
    set_mode = 1'b1;
    pulse_hour(6);
    pulse_min(19);
    pulse_clr();
    chk("al_setup", min1, 8'h29);
    chk("al_set_off", {7'd0, alarm}, 8'h00);
    set_mode = 1'b0;
    cyc(236);
    chk("al_before", {7'd0, alarm}, 8'h00);
    cyc(4);
    chk("al_min30", min1, 8'h30);
    chk("al_lag", {7'd0, alarm}, 8'h00);
    cyc(1);
    chk("al_rise", {7'd0, alarm}, 8'h01);
    cyc(239);
    chk("al_min31", min1, 8'h31);
    chk("al_still", {7'd0, alarm}, 8'h01);
    cyc(1);
    chk("al_drop", {7'd0, alarm}, 8'h00);
    amin = 8'h31; cyc(1);
    chk("al_rematch", {7'd0, alarm}, 8'h01);
    set_mode = 1'b1; cyc(1);
    chk("al_setmode_drop", {7'd0, alarm}, 8'h00);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/time_counter.md
# time_counter

Timekeeping core feeding the display multiplexer. It generates a 1 Hz tick from the system clock and keeps a 24-hour time of day as packed BCD hours, minutes and seconds. It accepts set-mode increment buttons and optionally flags an alarm match. Its `hour1`/`min1`/`sec1` outputs connect directly to the display stage's current-time inputs.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: `clk` cycles per second; must be ≥ 2.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, asynchronous and active-high.
- `set_mode` in 1: level input. 0 = run, 1 = set (time frozen, buttons active).
- `inc_hour` in 1: debounced button level. Rising edge increments hours in set mode.
- `inc_min` in 1: debounced button level. Rising edge increments minutes in set mode.
- `clr_sec` in 1: debounced button level. Rising edge zeroes seconds and the prescaler, in either mode.
- `ahour` in 8: alarm hour, BCD. Present only with `TIME_ALARM_EN`.
- `amin` in 8: alarm minute, BCD. Present only with `TIME_ALARM_EN`.
- `hour1` out 8: hours, BCD `[7:4]` tens and `[3:0]` units, range 00–23.
- `min1` out 8: minutes, BCD, range 00–59.
- `sec1` out 8: seconds, BCD, range 00–59.
- `tick_1hz` out 1: one-cycle pulse on each seconds advance.
- `alarm` out 1: high while the running time's hour:minute equals the alarm time.

## Operation
- **Prescaler `pre`**: counts 0..`TICK_DIV`-1.
  - Internal strobe `s` = (`pre` == `TICK_DIV`-1) && !`set_mode`.
  - On `s`, `pre` goes to 0. Otherwise it increments.
  - In set mode, `pre` is held at 0.
- **BCD increment rule**, applied to every field:
  - Units 9 → 0 with carry into tens.
  - Seconds and minutes wrap 59 → 00.
  - Hours wrap 23 → 00, checked as a whole byte 0x23.
  - Non-BCD codes never occur.
- **Run mode, on `s`**:
  - `sec1` increments.
  - On 59 → 00, `min1` increments.
  - On minutes 59 → 00, `hour1` increments.
  - All carries resolve on the same edge, e.g. 23:59:59 → 00:00:00 in one cycle.
- **Edge detect**: each button has a `*_q` register (reset 0). A rising edge is `btn && !btn_q`. Holding a button produces exactly one event.
- **Set mode**:
  - `inc_min` rises: minutes +1, wrapping 59 → 00 with no carry into hours.
  - `inc_hour` rises: hours +1, wrapping 23 → 00.
  - Both edges in the same cycle: both fields update.
- **Run mode, buttons**: `inc_hour` and `inc_min` edges are discarded. Their `*_q` registers still track the inputs.
- **`clr_sec` rising edge**:
  - Sets `sec1` = 00 and `pre` = 0 in either mode.
  - Takes priority over a coincident `s`: seconds go to 00 and no minute carry occurs.
- **Leaving set mode** (1 → 0): `pre` starts from 0, so the first advance occurs `TICK_DIV` cycles later.
- **Alarm**: see Configuration.
- **Reset (`rst` high at any time)**:
  - Asynchronously forces `hour1` = `min1` = `sec1` = 0x00, `pre` = 0, `tick_1hz` = 0, `alarm` = 0, all `*_q` = 0.
  - Counting resumes from 00:00:00 on release.

## Timing
- All outputs are registered.
- On the edge where `s` is true, the seconds field updates and `tick_1hz` goes high for exactly the following cycle.
- After reset release, the first advance happens on the `TICK_DIV`-th rising edge of `clk`. `sec1` = 0x01 from then on.
- Button edge to field update: the input must be high at a `clk` edge where its `*_q` is 0. The field changes on that same edge.
- `alarm` lags the time match by one cycle.

## Configuration
`TIME_ALARM_EN`:
- **Defined**:
  - `ahour` and `amin` ports exist.
  - `alarm` is registered as (`hour1` == `ahour`) && (`min1` == `amin`) && !`set_mode`.
  - It stays high for the full matching minute and drops on the first cycle the match or run mode is lost.
- **Undefined**: `ahour`/`amin` are absent, `alarm` is tied 0, and no comparator logic is generated.

## Test plan
All scenarios use `TICK_DIV` = 4.
- **Reset and first tick**: assert `rst` mid-count, release, run 4 clocks → `sec1` 0x00 until the 4th edge, then 0x01. `tick_1hz` is high for exactly one cycle.
- **Full rollover**: set 23:59:58 via set mode, then run 8 clocks → 23:59:59, then 00:00:00 in a single edge. `tick_1hz` pulses twice.
- **Set mode buttons**:
  - Hold `inc_min` high for 10 cycles from min 0x59 → 0x00 once, `hour1` unchanged.
  - `inc_hour` from 0x23 → 0x00.
  - `sec1` frozen throughout.
- **Run mode discard**: pulse `inc_hour` and `inc_min` while running → no field change. `clr_sec` at sec 0x37 → 0x00 with `pre` = 0, next advance 4 cycles later.
- **Simultaneous events**: `clr_sec` edge in the same cycle as `s` at sec 0x59, min 0x10 → `sec1` = 0x00 and `min1` stays 0x10.
- **Alarm** (`TIME_ALARM_EN`), with `ahour`/`amin` = 0x07/0x30:
  - Time reaches 07:30:00 → `alarm` rises one cycle later.
  - Alarm drops at 07:31:00, or immediately when `set_mode` goes to 1.
